// File: rtl/issue_arbiter.sv
// ---------------------------------------------------------------------------
// issue_arbiter
//   Issue scheduler between the reservation stations and the execution units.
//   Each cycle it grants at most one ready station (int, ld/st, mul, div) so
//   that no two results ever reach the common data bus in the same cycle. It
//   also sequences the non-pipelined divider and drives the registered CDB
//   owner select.
//
//   A shift register of CDB slot reservations s[0..DIV_LAT-1] moves one step
//   toward s[0] per cycle. s[0] owns the CDB this cycle. A grant to a unit of
//   latency L claims s[L-1] after the shift, so its result appears L cycles
//   after issue.
//
// Optional feature (macro ISSUE_ARB_RR_EN):
//   When defined, a 1-bit round-robin pointer settles ld vs int ties.
//   When undefined, ld always wins over int and no pointer flop exists.
//
// Ports:
//   i_clk        core clock
//   i_rst_n      synchronous active-low reset
//   i_flush      mispredict/abort, clears all in-flight reservations
//   i_ready_*    station holds an issuable op (int, ld, mul, div)
//   o_issue_*    grant to station (combinational, one-hot or zero)
//   o_div_busy   divider occupied (registered)
//   o_cdb_valid  a result owns the CDB this cycle (registered)
//   o_cdb_owner  CDB owner: 0 int, 1 ld, 2 mul, 3 div (registered)
// ---------------------------------------------------------------------------
module issue_arbiter #(
  parameter int INT_LAT = 1,
  parameter int LD_LAT  = 2,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 7
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_flush,
  input  logic       i_ready_int,
  input  logic       i_ready_ld,
  input  logic       i_ready_mul,
  input  logic       i_ready_div,
  output logic       o_issue_int,
  output logic       o_issue_ld,
  output logic       o_issue_mul,
  output logic       o_issue_div,
  output logic       o_div_busy,
  output logic       o_cdb_valid,
  output logic [1:0] o_cdb_owner
);

  localparam int CNT_W = (DIV_LAT > 2) ? $clog2(DIV_LAT) : 1;
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

  localparam logic [1:0] OWN_INT = 2'd0;
  localparam logic [1:0] OWN_LD  = 2'd1;
  localparam logic [1:0] OWN_MUL = 2'd2;
  localparam logic [1:0] OWN_DIV = 2'd3;

  // A unit of latency lat may issue when s[lat] is empty, because s[lat]
  // shifts into the slot it would claim. The longest latency lands past the
  // end of the register and is always free.
  function automatic logic slot_free(input logic [DIV_LAT-1:0] vld, input int lat);
    logic [DIV_LAT-1:0] sh;
    sh = vld >> lat;
    if (lat >= DIV_LAT) begin
      slot_free = 1'b1;
    end else begin
      slot_free = ~sh[0];
    end
  endfunction

  logic [DIV_LAT-1:0]      r_vld;
  logic [DIV_LAT-1:0][1:0] r_own;
  logic [CNT_W-1:0]        r_div_cnt;
  logic                    r_div_busy;

  logic [DIV_LAT-1:0]      w_vld_nxt;
  logic [DIV_LAT-1:0][1:0] w_own_nxt;
  logic [CNT_W-1:0]        w_cnt_nxt;

  logic w_elig_int, w_elig_ld, w_elig_mul, w_elig_div;
  logic w_gnt_int, w_gnt_ld, w_gnt_mul, w_gnt_div;

`ifdef ISSUE_ARB_RR_EN
  // 1: ld favoured on the next tie, 0: int favoured.
  logic r_rr_ptr;
`endif

  // Reset and flush both suppress eligibility, so grants drop to zero.
  assign w_elig_div = i_rst_n & ~i_flush & i_ready_div & ~r_div_busy & slot_free(r_vld, DIV_LAT);
  assign w_elig_mul = i_rst_n & ~i_flush & i_ready_mul & slot_free(r_vld, MUL_LAT);
  assign w_elig_ld  = i_rst_n & ~i_flush & i_ready_ld  & slot_free(r_vld, LD_LAT);
  assign w_elig_int = i_rst_n & ~i_flush & i_ready_int & slot_free(r_vld, INT_LAT);

  // Fixed-priority grant select: div > mul > {ld, int}.
  always_comb begin
    w_gnt_int = 1'b0;
    w_gnt_ld  = 1'b0;
    w_gnt_mul = 1'b0;
    w_gnt_div = 1'b0;
    if (w_elig_div) begin
      w_gnt_div = 1'b1;
    end else if (w_elig_mul) begin
      w_gnt_mul = 1'b1;
    end else if (w_elig_ld && w_elig_int) begin
`ifdef ISSUE_ARB_RR_EN
      if (r_rr_ptr) begin
        w_gnt_ld = 1'b1;
      end else begin
        w_gnt_int = 1'b1;
      end
`else
      w_gnt_ld = 1'b1;
`endif
    end else if (w_elig_ld) begin
      w_gnt_ld = 1'b1;
    end else if (w_elig_int) begin
      w_gnt_int = 1'b1;
    end else begin
      w_gnt_int = 1'b0;
    end
  end

  // Next reservation state: shift toward s[0], then claim the granted slot.
  always_comb begin
    w_vld_nxt = {1'b0, r_vld[DIV_LAT-1:1]};
    w_own_nxt = {2'b00, r_own[DIV_LAT-1:1]};
    if (w_gnt_div) begin
      w_vld_nxt[DIV_LAT-1] = 1'b1;
      w_own_nxt[DIV_LAT-1] = OWN_DIV;
    end else if (w_gnt_mul) begin
      w_vld_nxt[MUL_LAT-1] = 1'b1;
      w_own_nxt[MUL_LAT-1] = OWN_MUL;
    end else if (w_gnt_ld) begin
      w_vld_nxt[LD_LAT-1] = 1'b1;
      w_own_nxt[LD_LAT-1] = OWN_LD;
    end else if (w_gnt_int) begin
      w_vld_nxt[INT_LAT-1] = 1'b1;
      w_own_nxt[INT_LAT-1] = OWN_INT;
    end else begin
      w_vld_nxt[0] = r_vld[1];
    end
  end

  // Divider occupancy countdown: loads on a div grant, counts down to zero.
  always_comb begin
    if (w_gnt_div) begin
      w_cnt_nxt = DIV_LOAD;
    end else if (r_div_cnt != {CNT_W{1'b0}}) begin
      w_cnt_nxt = r_div_cnt - CNT_W'(1);
    end else begin
      w_cnt_nxt = r_div_cnt;
    end
  end

  // Reservation register, divider counter and registered busy flag.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_vld      <= {DIV_LAT{1'b0}};
      r_own      <= {DIV_LAT{2'b00}};
      r_div_cnt  <= {CNT_W{1'b0}};
      r_div_busy <= 1'b0;
    end else if (i_flush) begin
      r_vld      <= {DIV_LAT{1'b0}};
      r_own      <= {DIV_LAT{2'b00}};
      r_div_cnt  <= {CNT_W{1'b0}};
      r_div_busy <= 1'b0;
    end else begin
      r_vld      <= w_vld_nxt;
      r_own      <= w_own_nxt;
      r_div_cnt  <= w_cnt_nxt;
      r_div_busy <= (w_cnt_nxt != {CNT_W{1'b0}});
    end
  end

`ifdef ISSUE_ARB_RR_EN
  // Round-robin pointer: after a win, favour the other side; flush holds it.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rr_ptr <= 1'b0;
    end else if (w_gnt_ld) begin
      r_rr_ptr <= 1'b0;
    end else if (w_gnt_int) begin
      r_rr_ptr <= 1'b1;
    end else begin
      r_rr_ptr <= r_rr_ptr;
    end
  end
`endif

  assign o_issue_int = w_gnt_int;
  assign o_issue_ld  = w_gnt_ld;
  assign o_issue_mul = w_gnt_mul;
  assign o_issue_div = w_gnt_div;
  assign o_div_busy  = r_div_busy;
  assign o_cdb_valid = r_vld[0];
  assign o_cdb_owner = r_own[0];

endmodule

// File: tb/tb_issue_arbiter.sv
// ---------------------------------------------------------------------------
// tb_issue_arbiter
//   Directed-vector bench for issue_arbiter with default latencies
//   (1/2/4/7). Each vector drives one cycle's inputs after the falling edge,
//   then compares grants, o_div_busy and the CDB outputs against
//   hand-computed values. Ready vectors are packed {div, mul, ld, int}.
// ---------------------------------------------------------------------------
module tb_issue_arbiter;

  logic       clk;
  logic       rst_n_s;
  logic       flush_s;
  logic       rdy_int_s, rdy_ld_s, rdy_mul_s, rdy_div_s;
  logic       iss_int_s, iss_ld_s, iss_mul_s, iss_div_s;
  logic       div_busy_s;
  logic       cdb_valid_s;
  logic [1:0] cdb_owner_s;

  int n_vec;
  int n_err;

  issue_arbiter dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n_s),
    .i_flush     (flush_s),
    .i_ready_int (rdy_int_s),
    .i_ready_ld  (rdy_ld_s),
    .i_ready_mul (rdy_mul_s),
    .i_ready_div (rdy_div_s),
    .o_issue_int (iss_int_s),
    .o_issue_ld  (iss_ld_s),
    .o_issue_mul (iss_mul_s),
    .o_issue_div (iss_div_s),
    .o_div_busy  (div_busy_s),
    .o_cdb_valid (cdb_valid_s),
    .o_cdb_owner (cdb_owner_s)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every vector and reports miscompares.
  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec = n_vec + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs and compare that cycle's outputs.
  task automatic cyc(input string name, input logic rst_n, input logic flush,
                     input logic [3:0] rdy, input logic [3:0] e_gnt,
                     input logic e_busy, input logic e_cv, input logic [1:0] e_own);
    @(negedge clk);
    rst_n_s   = rst_n;
    flush_s   = flush;
    rdy_div_s = rdy[3];
    rdy_mul_s = rdy[2];
    rdy_ld_s  = rdy[1];
    rdy_int_s = rdy[0];
    #1;
    check_eq({name, " gnt"}, {4'b0000, iss_div_s, iss_mul_s, iss_ld_s, iss_int_s}, {4'b0000, e_gnt});
    check_eq({name, " busy"}, {7'b0000000, div_busy_s}, {7'b0000000, e_busy});
    check_eq({name, " cdb"}, {5'b00000, cdb_valid_s, cdb_owner_s}, {5'b00000, e_cv, e_own});
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst_n_s   = 1'b0;
    flush_s   = 1'b0;
    rdy_int_s = 1'b1;
    rdy_ld_s  = 1'b1;
    rdy_mul_s = 1'b1;
    rdy_div_s = 1'b1;

    // Reset held with every station ready: nothing granted, outputs idle.
    cyc("rst0", 1'b0, 1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0, 2'd0);
    cyc("rst1", 1'b0, 1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0, 2'd0);

    // All four ready: div first, then mul/int interleave around reservations.
    cyc("pri0", 1'b1, 1'b0, 4'b1111, 4'b1000, 1'b0, 1'b0, 2'd0);
    cyc("pri1", 1'b1, 1'b0, 4'b1111, 4'b0100, 1'b1, 1'b0, 2'd0);
    cyc("pri2", 1'b1, 1'b0, 4'b1111, 4'b0100, 1'b1, 1'b0, 2'd0);
    cyc("pri3", 1'b1, 1'b0, 4'b1111, 4'b0001, 1'b1, 1'b0, 2'd0);
    cyc("pri4", 1'b1, 1'b0, 4'b1111, 4'b0100, 1'b1, 1'b1, 2'd0);
    cyc("pri5", 1'b1, 1'b0, 4'b1111, 4'b0100, 1'b1, 1'b1, 2'd2);
    cyc("pri6", 1'b1, 1'b0, 4'b1111, 4'b0100, 1'b1, 1'b1, 2'd2);
    cyc("pri7", 1'b1, 1'b0, 4'b1111, 4'b1000, 1'b0, 1'b1, 2'd3);

    // Flush drains the pipe: no grants that cycle, everything clear after.
    cyc("fl_a", 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b1, 1'b1, 2'd2);
    cyc("fl_b", 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0);

    // Lone int: result on the CDB the next cycle.
    cyc("int0", 1'b1, 1'b0, 4'b0001, 4'b0001, 1'b0, 1'b0, 2'd0);
    cyc("int1", 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd0);
    cyc("int2", 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0);

    // Slot conflict: div reserves cycle +7, int at +6 must wait one cycle.
    cyc("slt0", 1'b1, 1'b0, 4'b1000, 4'b1000, 1'b0, 1'b0, 2'd0);
    for (int i = 1; i <= 5; i++) begin
      cyc($sformatf("slt%0d", i), 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0);
    end
    cyc("slt6", 1'b1, 1'b0, 4'b0001, 4'b0000, 1'b1, 1'b0, 2'd0);
    cyc("slt7", 1'b1, 1'b0, 4'b0001, 4'b0001, 1'b0, 1'b1, 2'd3);
    cyc("slt8", 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd0);
    cyc("slt9", 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0);

    // Flush kills an in-flight mul and the divider occupancy.
    cyc("fm0", 1'b1, 1'b0, 4'b0100, 4'b0100, 1'b0, 1'b0, 2'd0);
    cyc("fm1", 1'b1, 1'b0, 4'b1000, 4'b1000, 1'b0, 1'b0, 2'd0);
    cyc("fm2", 1'b1, 1'b1, 4'b0001, 4'b0000, 1'b1, 1'b0, 2'd0);
    cyc("fm3", 1'b1, 1'b0, 4'b1000, 4'b1000, 1'b0, 1'b0, 2'd0);
    cyc("fm4", 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0);
    cyc("fm5", 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0);
    cyc("fm6", 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0);

    // ld vs int from reset with only those two ready.
    cyc("li_r", 1'b0, 1'b0, 4'b0011, 4'b0000, 1'b0, 1'b0, 2'd0);
`ifdef ISSUE_ARB_RR_EN
    cyc("li0", 1'b1, 1'b0, 4'b0011, 4'b0001, 1'b0, 1'b0, 2'd0);
    cyc("li1", 1'b1, 1'b0, 4'b0011, 4'b0010, 1'b0, 1'b1, 2'd0);
    cyc("li2", 1'b1, 1'b0, 4'b0011, 4'b0010, 1'b0, 1'b0, 2'd0);
    cyc("li3", 1'b1, 1'b0, 4'b0011, 4'b0010, 1'b0, 1'b1, 2'd1);
`else
    cyc("li0", 1'b1, 1'b0, 4'b0011, 4'b0010, 1'b0, 1'b0, 2'd0);
    cyc("li1", 1'b1, 1'b0, 4'b0011, 4'b0010, 1'b0, 1'b0, 2'd0);
    cyc("li2", 1'b1, 1'b0, 4'b0011, 4'b0010, 1'b0, 1'b1, 2'd1);
    cyc("li3", 1'b1, 1'b0, 4'b0011, 4'b0010, 1'b0, 1'b1, 2'd1);
`endif
    cyc("li4", 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd1);
    cyc("li5", 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd1);
    cyc("li6", 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0);
    // Fresh tie after ld grants: pointer now favours int; fixed mode keeps ld.
`ifdef ISSUE_ARB_RR_EN
    cyc("li7", 1'b1, 1'b0, 4'b0011, 4'b0001, 1'b0, 1'b0, 2'd0);
`else
    cyc("li7", 1'b1, 1'b0, 4'b0011, 4'b0010, 1'b0, 1'b0, 2'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
